// File: rtl/missile_launcher.sv
// Fire-control scheduler for the player's missile slots: conditions the fire button,
// launches the lowest free slot on a toggle-encoded bus, then waits for ack and cools down.
module missile_launcher #(
    parameter int NUM_SLOTS       = 8,
    parameter int COOLDOWN_CYCLES = 4000000,
    parameter int ACK_TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fire_btn,
    input  logic                 game_en,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    output logic [NUM_SLOTS-1:0] btn_missle_en,
    output logic                 launch_pulse,
    output logic [2:0]           launched_slot,
    output logic                 all_busy,
    output logic [15:0]          shots_fired,
    output logic [7:0]           dropped,
    output logic                 fault
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        COOLDOWN
    } state_t;

    state_t             state;
    logic               s1, s2, s3;
    logic               fire_edge;
    logic [ACK_W-1:0]   ack_cnt;
    logic [23:0]        cool_cnt;
    logic [2:0]         free_idx;
    logic [NUM_SLOTS-1:0] free_mask;
    logic               launch_ok;
    logic               drop_now;

    // s1/s2 resolve metastability; s3 remembers the previous synchronized level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= fire_btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fire_edge = s2 & ~s3;
    assign all_busy  = &slot_busy;

    // Descending scan so the lowest free index is the last one written
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                free_idx = 3'(i);
            end
        end
        free_mask = NUM_SLOTS'(1) << free_idx;
    end

    assign launch_ok = fire_edge & game_en & ~all_busy & (state == IDLE);
    assign drop_now  = fire_edge & ~launch_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            btn_missle_en <= '0;
            launch_pulse  <= 1'b0;
            launched_slot <= '0;
            shots_fired   <= '0;
            dropped       <= '0;
            fault         <= 1'b0;
            ack_cnt       <= '0;
            cool_cnt      <= '0;
        end else begin
            launch_pulse <= 1'b0;

            if (drop_now && dropped != 8'hFF) begin
                dropped <= dropped + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (launch_ok) begin
                        btn_missle_en <= btn_missle_en ^ free_mask;
                        launch_pulse  <= 1'b1;
                        launched_slot <= free_idx;
                        shots_fired   <= shots_fired + 16'd1;
                        ack_cnt       <= '0;
                        state         <= WAIT_ACK;
                    end
                end

                // A missing ack is flagged but the launch toggle is left in place
                WAIT_ACK: begin
                    if (slot_busy[launched_slot]) begin
                        cool_cnt <= 24'(COOLDOWN_CYCLES - 1);
                        state    <= COOLDOWN;
                    end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                        fault    <= 1'b1;
                        cool_cnt <= 24'(COOLDOWN_CYCLES - 1);
                        state    <= COOLDOWN;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end

                COOLDOWN: begin
                    if (cool_cnt == 24'd0) begin
                        state <= IDLE;
                    end else begin
                        cool_cnt <= cool_cnt - 24'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_missile_launcher.sv
// Directed bench for missile_launcher with short cooldown/timeout so every
// boundary is reachable in a few cycles; expected values are hand-computed.
module tb_missile_launcher;

    logic       clk;
    logic       rst;
    logic       fire_btn;
    logic       game_en;
    logic [7:0] slot_busy;
    logic [7:0] btn_missle_en;
    logic       launch_pulse;
    logic [2:0] launched_slot;
    logic       all_busy;
    logic [15:0] shots_fired;
    logic [7:0] dropped;
    logic       fault;

    int checkCount = 0;
    int errorCount = 0;

    missile_launcher #(
        .NUM_SLOTS(8),
        .COOLDOWN_CYCLES(10),
        .ACK_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fire_btn(fire_btn),
        .game_en(game_en),
        .slot_busy(slot_busy),
        .btn_missle_en(btn_missle_en),
        .launch_pulse(launch_pulse),
        .launched_slot(launched_slot),
        .all_busy(all_busy),
        .shots_fired(shots_fired),
        .dropped(dropped),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        fire_btn = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // Returns at the negedge following the launch edge (k+2)
    task automatic applyStimulus();
        fire_btn = 1'b1;
        tick(1);
        fire_btn = 1'b0;
        tick(2);
    endtask

    initial begin
        rst = 1'b1;
        fire_btn = 1'b0;
        game_en = 1'b1;
        slot_busy = 8'h00;
        tick(2);
        checkOutput("rst_btn_en", 32'(btn_missle_en), 32'h00);
        checkOutput("rst_pulse", 32'(launch_pulse), 32'h0);
        checkOutput("rst_slot", 32'(launched_slot), 32'h0);
        checkOutput("rst_shots", 32'(shots_fired), 32'h0);
        checkOutput("rst_dropped", 32'(dropped), 32'h0);
        checkOutput("rst_fault", 32'(fault), 32'h0);
        rst = 1'b0;
        tick(1);

        $display("[TB] scenario 1: free slots, single fire");
        fire_btn = 1'b1;
        tick(1);
        checkOutput("t1_btn_k", 32'(btn_missle_en), 32'h00);
        fire_btn = 1'b0;
        tick(1);
        checkOutput("t1_btn_k1", 32'(btn_missle_en), 32'h00);
        checkOutput("t1_pulse_k1", 32'(launch_pulse), 32'h0);
        tick(1);
        checkOutput("t1_btn_k2", 32'(btn_missle_en), 32'h01);
        checkOutput("t1_pulse_k2", 32'(launch_pulse), 32'h1);
        checkOutput("t1_slot", 32'(launched_slot), 32'h0);
        checkOutput("t1_shots", 32'(shots_fired), 32'h1);
        checkOutput("t1_all_busy", 32'(all_busy), 32'h0);
        slot_busy = 8'h01;
        tick(1);
        checkOutput("t1_pulse_k3", 32'(launch_pulse), 32'h0);
        checkOutput("t1_btn_k3", 32'(btn_missle_en), 32'h01);
        tick(15);

        $display("[TB] scenario 2: lowest free slot is 3");
        doReset();
        slot_busy = 8'h07;
        applyStimulus();
        checkOutput("t2_btn", 32'(btn_missle_en), 32'h08);
        checkOutput("t2_slot", 32'(launched_slot), 32'h3);
        checkOutput("t2_pulse", 32'(launch_pulse), 32'h1);
        checkOutput("t2_shots", 32'(shots_fired), 32'h1);
        slot_busy = 8'h0F;
        tick(15);

        $display("[TB] scenario 3: all busy, drop saturation");
        doReset();
        slot_busy = 8'hFF;
        #1;
        checkOutput("t3_all_busy", 32'(all_busy), 32'h1);
        applyStimulus();
        checkOutput("t3_btn", 32'(btn_missle_en), 32'h00);
        checkOutput("t3_pulse", 32'(launch_pulse), 32'h0);
        checkOutput("t3_dropped1", 32'(dropped), 32'h01);
        for (int i = 0; i < 300; i++) begin
            fire_btn = 1'b1;
            tick(1);
            fire_btn = 1'b0;
            tick(1);
        end
        tick(3);
        checkOutput("t3_dropped_sat", 32'(dropped), 32'hFF);
        checkOutput("t3_shots", 32'(shots_fired), 32'h0);
        slot_busy = 8'hFE;
        #1;
        checkOutput("t3_not_all_busy", 32'(all_busy), 32'h0);

        $display("[TB] scenario 4: ack timeout sets fault");
        doReset();
        slot_busy = 8'h00;
        applyStimulus();
        checkOutput("t4_shots1", 32'(shots_fired), 32'h1);
        tick(3);
        checkOutput("t4_fault_early", 32'(fault), 32'h0);
        tick(1);
        checkOutput("t4_fault_set", 32'(fault), 32'h1);
        tick(7);
        fire_btn = 1'b1;
        tick(1);
        fire_btn = 1'b0;
        tick(1);
        fire_btn = 1'b1;
        tick(1);
        checkOutput("t4_drop_last_cool", 32'(dropped), 32'h01);
        checkOutput("t4_btn_kept", 32'(btn_missle_en), 32'h01);
        tick(1);
        checkOutput("t4_pulse_wait", 32'(launch_pulse), 32'h0);
        tick(1);
        checkOutput("t4_pulse_relaunch", 32'(launch_pulse), 32'h1);
        checkOutput("t4_btn_toggled_back", 32'(btn_missle_en), 32'h00);
        checkOutput("t4_shots2", 32'(shots_fired), 32'h2);
        checkOutput("t4_fault_sticky", 32'(fault), 32'h1);
        fire_btn = 1'b0;
        slot_busy = 8'h01;
        tick(15);

        $display("[TB] scenario 5: fire during cooldown, fastest repeat");
        doReset();
        slot_busy = 8'h00;
        applyStimulus();
        slot_busy = 8'h01;
        tick(3);
        fire_btn = 1'b1;
        tick(1);
        fire_btn = 1'b0;
        tick(2);
        checkOutput("t5_drop_cool", 32'(dropped), 32'h01);
        checkOutput("t5_btn_cool", 32'(btn_missle_en), 32'h01);
        checkOutput("t5_pulse_cool", 32'(launch_pulse), 32'h0);
        tick(3);
        fire_btn = 1'b1;
        tick(1);
        fire_btn = 1'b0;
        tick(1);
        checkOutput("t5_pulse_pre", 32'(launch_pulse), 32'h0);
        checkOutput("t5_btn_pre", 32'(btn_missle_en), 32'h01);
        tick(1);
        checkOutput("t5_pulse_second", 32'(launch_pulse), 32'h1);
        checkOutput("t5_btn_second", 32'(btn_missle_en), 32'h03);
        checkOutput("t5_slot_second", 32'(launched_slot), 32'h1);
        checkOutput("t5_shots", 32'(shots_fired), 32'h2);
        checkOutput("t5_dropped_final", 32'(dropped), 32'h01);
        slot_busy = 8'h03;
        tick(15);

        $display("[TB] scenario 6: async reset mid-cooldown");
        doReset();
        slot_busy = 8'h00;
        applyStimulus();
        slot_busy = 8'h01;
        tick(13);
        slot_busy = 8'h03;
        applyStimulus();
        checkOutput("t6_btn_pre", 32'(btn_missle_en), 32'h05);
        checkOutput("t6_slot_pre", 32'(launched_slot), 32'h2);
        slot_busy = 8'h07;
        tick(4);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_btn", 32'(btn_missle_en), 32'h00);
        checkOutput("t6_rst_pulse", 32'(launch_pulse), 32'h0);
        checkOutput("t6_rst_slot", 32'(launched_slot), 32'h0);
        checkOutput("t6_rst_shots", 32'(shots_fired), 32'h0);
        checkOutput("t6_rst_dropped", 32'(dropped), 32'h0);
        checkOutput("t6_rst_fault", 32'(fault), 32'h0);
        tick(1);
        rst = 1'b0;
        slot_busy = 8'h00;
        tick(1);
        applyStimulus();
        checkOutput("t6_post_btn", 32'(btn_missle_en), 32'h01);
        checkOutput("t6_post_slot", 32'(launched_slot), 32'h0);
        checkOutput("t6_post_pulse", 32'(launch_pulse), 32'h1);
        checkOutput("t6_post_shots", 32'(shots_fired), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/missile_launcher.md
# missile_launcher

Fire-control scheduler for the player's eight-slot missile datapath in the VGA game peripheral.
- Synchronizes the raw fire button and detects its rising edge.
- Picks the lowest-numbered free missile slot and launches it by toggling that slot's bit on the toggle-encoded `btn_missle_en` bus.
- Waits for the slot to report in-flight, then enforces a cooldown.
- Exposes shot and drop statistics to the SoC.

## Interface
Parameters:
- `NUM_SLOTS`, 8: number of missile slots; width of the slot buses.
- `COOLDOWN_CYCLES`, 4000000: cycles spent in COOLDOWN after each launch. Must be ≥1.
- `ACK_TIMEOUT`, 1024: maximum cycles to wait for a slot acknowledge. Must be ≥1.

Ports:
- `clk`  in  1  system clock (single clock domain).
- `rst`  in  1  reset; asynchronous, active-high.
- `fire_btn`  in  1  raw fire button, asynchronous to `clk`.
- `game_en`  in  1  while low, fire edges are discarded and counted as drops.
- `slot_busy`  in  NUM_SLOTS  bit i high while missile i is in flight.
- `btn_missle_en`  out  NUM_SLOTS  toggle-encoded launch bus to the player datapath.
- `launch_pulse`  out  1  one-cycle strobe, coincident with a `btn_missle_en` toggle.
- `launched_slot`  out  3  index of the most recent launch; held between launches.
- `all_busy`  out  1  combinational `&slot_busy`.
- `shots_fired`  out  16  launch count; wraps 0xFFFF→0.
- `dropped`  out  8  dropped-request count; saturates at 0xFF.
- `fault`  out  1  sticky ack-timeout flag; cleared only by `rst`.

## Operation
Input conditioning:
- 2-FF synchronizer `s1`→`s2`, plus a history register `s3`.
- `fire_edge = s2 & ~s3`.

FSM states: IDLE, WAIT_ACK, COOLDOWN. Reset state is IDLE.

IDLE:
- On `fire_edge & game_en & ~all_busy`:
  - `i` = lowest index with `slot_busy[i]==0`.
  - Toggle `btn_missle_en[i]`.
  - Assert `launch_pulse`.
  - `launched_slot <= i`.
  - `shots_fired++`.
  - Clear the ack counter and go to WAIT_ACK.
- On `fire_edge` with `~game_en` or `all_busy`: `dropped++` (saturating); stay in IDLE.

WAIT_ACK:
- `slot_busy[launched_slot]==1` → COOLDOWN; load cooldown counter with `COOLDOWN_CYCLES-1`.
- Otherwise, when the ack counter reaches `ACK_TIMEOUT-1` → set `fault`, go to COOLDOWN (same load). `btn_missle_en` is not reverted.

COOLDOWN:
- Decrement the counter each cycle.
- On the cycle the counter is 0 → IDLE.
- Total cycles spent in COOLDOWN = `COOLDOWN_CYCLES`.

Common rules:
- Any `fire_edge` seen outside IDLE → `dropped++`. Requests are never queued.
- Arithmetic: cooldown counter is 24 bits; ack counter is `$clog2(ACK_TIMEOUT+1)` bits; `shots_fired` wraps; `dropped` saturates.
- A slot that goes free and busy again on its own causes no action; only the latched slot is checked in WAIT_ACK.

Reset values (all outputs and registers; `rst` mid-operation aborts any state immediately):
- `btn_missle_en`=0, `launch_pulse`=0, `launched_slot`=0.
- `shots_fired`=0, `dropped`=0, `fault`=0.
- Sync registers = 0; FSM = IDLE.

## Timing
- `fire_btn` is first sampled high at edge k.
  - `s2` goes high at k+1.
  - `btn_missle_en` toggles and `launch_pulse` asserts at edge k+2.
  - `launch_pulse` deasserts at k+3.
- A button held high produces exactly one edge; re-arming needs `s3`=0, i.e. the button low for ≥1 cycle after synchronization.
- Fastest repeat when ack arrives the cycle after launch:
  - launch at edge T; WAIT_ACK at T+1 sees busy → COOLDOWN from T+2.
  - IDLE at T+2+`COOLDOWN_CYCLES`.
  - The next launch can occur at the first edge an IDLE fire_edge is present.
- Simultaneous `fire_edge` and a WAIT_ACK→COOLDOWN transition: counts as dropped.
- Slot selection uses `slot_busy` as sampled in the launch cycle.
- Slot selection is a combinational priority encoder with no extra latency.

## Test plan
Parameters for all scenarios: `COOLDOWN_CYCLES`=10, `ACK_TIMEOUT`=4.
1. Reset, then `slot_busy`=0x00 and a fire pulse:
   - `btn_missle_en` 0x00→0x01 exactly 2 edges after sampling.
   - `launch_pulse` high for 1 cycle; `launched_slot`=0; `shots_fired`=1.
2. `slot_busy`=0x07 and fire → bit 3 toggles (`btn_missle_en` 0x00→0x08); `launched_slot`=3.
3. `slot_busy`=0xFF and fire → no toggle, `dropped`=1. Repeat 300 fires → `dropped` saturates at 255.
4. Launch, then hold `slot_busy` low → `fault`=1 after 4 WAIT_ACK cycles; IDLE 10 cycles later; `fault` stays set.
5. Launch with immediate ack; fire again at cooldown cycle 5 → `dropped`+1, no toggle. Fire after IDLE → second launch.
6. Assert `rst` mid-COOLDOWN with `btn_missle_en`=0x05 → all outputs 0 and FSM IDLE within the same cycle (asynchronous); a fire after release launches slot 0.
